// File: rtl/fpnew_divsqrt_result_buffer.sv
// FIFO result buffer between the iterative div/sqrt unit and writeback.
// Also keeps a sticky OR of retired status flags for the fflags CSR.
module fpnew_divsqrt_result_buffer #(
    parameter int unsigned WIDTH     = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned TAG_WIDTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_result_i,
    input  logic [4:0]                   in_status_i,
    input  logic                         in_ext_bit_i,
    input  logic [TAG_WIDTH-1:0]         in_tag_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [WIDTH-1:0]             out_result_o,
    output logic [4:0]                   out_status_o,
    output logic                         out_ext_bit_o,
    output logic [TAG_WIDTH-1:0]         out_tag_o,
    output logic [$clog2(DEPTH+1)-1:0]   usage_o,
    output logic [4:0]                   status_acc_o,
    input  logic                         status_clr_i,
    output logic                         busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH-1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0]     res_q [DEPTH];
    logic [4:0]           sts_q [DEPTH];
    logic                 ext_q [DEPTH];
    logic [TAG_WIDTH-1:0] tag_q [DEPTH];

    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       acc_q, acc_d;
    logic             push, pop, push_eff, pop_eff;

    // Explicit compare keeps the wrap correct for non-power-of-two DEPTH.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_ready_o   = (cnt_q != CNT_FULL);
    assign out_valid_o  = (cnt_q != '0);
    assign push         = in_valid_i & in_ready_o;
    assign pop          = out_valid_o & out_ready_i;
    assign push_eff     = push & ~flush_i;
    assign pop_eff      = pop & ~flush_i;

    assign out_result_o  = res_q[rd_q];
    assign out_status_o  = sts_q[rd_q];
    assign out_ext_bit_o = ext_q[rd_q];
    assign out_tag_o     = tag_q[rd_q];
    assign usage_o       = cnt_q;
    assign busy_o        = out_valid_o;
    assign status_acc_o  = acc_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        acc_d = acc_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_eff) wr_d = ptr_inc(wr_q);
            if (pop_eff)  rd_d = ptr_inc(rd_q);
            if (push_eff && !pop_eff)      cnt_d = cnt_q + CNT_W'(1);
            else if (pop_eff && !push_eff) cnt_d = cnt_q - CNT_W'(1);
        end
        // A clear coinciding with a pop keeps the popped flags so they are not lost.
        if (status_clr_i) acc_d = pop_eff ? sts_q[rd_q] : 5'b0;
        else if (pop_eff) acc_d = acc_q | sts_q[rd_q];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_eff && !rst_i) begin
            res_q[wr_q] <= in_result_i;
            sts_q[wr_q] <= in_status_i;
            ext_q[wr_q] <= in_ext_bit_i;
            tag_q[wr_q] <= in_tag_i;
        end
    end

endmodule

// File: tb/tb_fpnew_divsqrt_result_buffer.sv
// Scoreboard bench: a queue model of the buffer is compared against the DUT every cycle.
module tb_fpnew_divsqrt_result_buffer;

    localparam int DEPTH = 3;
    localparam int UW    = $clog2(DEPTH+1);

    typedef struct {
        logic [63:0] res;
        logic [4:0]  st;
        logic        ext;
        logic [7:0]  tag;
    } ent_t;

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, status_clr, in_ext;
    logic [63:0]   in_result;
    logic [4:0]    in_status;
    logic [7:0]    in_tag;
    logic          in_ready, out_valid, out_ext, busy;
    logic [63:0]   out_result;
    logic [4:0]    out_status, acc;
    logic [7:0]    out_tag;
    logic [UW-1:0] usage;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en = 1'b0;
    ent_t q[$];
    logic [4:0] m_acc = 5'b0;
    logic [4:0] saved_acc;

    always #5 clk = ~clk;

    fpnew_divsqrt_result_buffer #(.WIDTH(64), .DEPTH(DEPTH), .TAG_WIDTH(8)) u_dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_result_i(in_result),
        .in_status_i(in_status), .in_ext_bit_i(in_ext), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_result_o(out_result),
        .out_status_o(out_status), .out_ext_bit_o(out_ext), .out_tag_o(out_tag),
        .usage_o(usage), .status_acc_o(acc), .status_clr_i(status_clr), .busy_o(busy)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a queue of held entries plus the sticky flags.
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_acc = 5'b0;
        end else begin
            bit   pop, push;
            ent_t e;
            pop  = (q.size() != 0) && out_ready && !flush;
            push = in_valid && (q.size() != DEPTH) && !flush;
            if (status_clr)
                m_acc = pop ? q[0].st : 5'b0;
            else if (pop)
                m_acc = m_acc | q[0].st;
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (push) begin
                    e.res = in_result; e.st = in_status; e.ext = in_ext; e.tag = in_tag;
                    q.push_back(e);
                end
            end
        end
    end

    // Monitor: compares everything visible against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, q.size() != DEPTH);
            check("out_valid", out_valid, q.size() != 0);
            check("usage", usage, q.size());
            check("busy", busy, q.size() != 0);
            check("status_acc", acc, m_acc);
            check("usage_bound", usage <= DEPTH, 1);
            if (q.size() != 0) begin
                check("head_result", out_result, q[0].res);
                check("head_status", out_status, q[0].st);
                check("head_ext", out_ext, q[0].ext);
                check("head_tag", out_tag, q[0].tag);
            end
        end
    end

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0; status_clr = 0;
    endtask

    task automatic set_entry(input logic [63:0] r, input logic [4:0] s, input logic [7:0] t);
        in_result = r; in_status = s; in_tag = t; in_ext = $urandom_range(0, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_usage"}, usage, 0);
        check({tag, "_acc"}, acc, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1; idle_inputs(); set_entry(64'h0, 5'h0, 8'h0);
        repeat (2) @(negedge clk);
        rst = 0; mon_en = 1;
        check_reset_vals("reset");

        // Single entry: visible one cycle after the push, then popped.
        set_entry(64'h3FF0_0000_0000_0000, 5'b00001, 8'h5A); in_valid = 1;
        @(negedge clk); in_valid = 0;
        check("single_valid", out_valid, 1);
        check("single_tag", out_tag, 8'h5A);
        check("single_result", out_result, 64'h3FF0_0000_0000_0000);
        check("single_usage", usage, 1);
        out_ready = 1;
        @(negedge clk); out_ready = 0;
        check("single_usage_after", usage, 0);
        check("single_acc", acc, 5'b00001);

        // Fill to capacity with back-pressure.
        for (int i = 1; i <= DEPTH; i++) begin
            set_entry({$urandom, $urandom}, 5'($urandom), 8'(i)); in_valid = 1;
            @(negedge clk);
        end
        check("full_ready", in_ready, 0);
        check("full_usage", usage, DEPTH);
        set_entry(64'hDEAD, 5'b0, 8'd99);
        repeat (3) begin
            @(negedge clk);
            check("full_refuse_ready", in_ready, 0);
        end
        check("full_head_tag", out_tag, 8'd1);
        // Pop while full with a push offered: the push must be refused.
        set_entry(64'hBEEF, 5'b0, 8'd77); out_ready = 1;
        @(negedge clk); in_valid = 0;
        check("after_pop_ready", in_ready, 1);
        check("after_pop_tag", out_tag, 8'd2);
        repeat (DEPTH) @(negedge clk);
        out_ready = 0;
        check("drained_usage", usage, 0);

        // Random concurrent stream; the monitor checks order and occupancy.
        for (int i = 0; i < 60; i++) begin
            set_entry({$urandom, $urandom}, 5'($urandom), 8'($urandom));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            status_clr = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        in_valid = 0; status_clr = 0; out_ready = 1;
        repeat (DEPTH + 1) @(negedge clk);
        out_ready = 0;

        // Flush with a simultaneous push and pop: both are dropped.
        status_clr = 1; @(negedge clk); status_clr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            set_entry({$urandom, $urandom}, 5'b01000, 8'(40 + i)); in_valid = 1;
            @(negedge clk);
        end
        saved_acc = m_acc;
        flush = 1; out_ready = 1; set_entry(64'h1, 5'b11111, 8'hEE);
        @(negedge clk); idle_inputs();
        check("flush_usage", usage, 0);
        check("flush_valid", out_valid, 0);
        check("flush_busy", busy, 0);
        check("flush_acc", acc, saved_acc);
        check("flush_acc_zero", acc, 0);

        // Clear colliding with a pop keeps the popped flags.
        set_entry(64'h2, 5'b10000, 8'h11); in_valid = 1;
        @(negedge clk); in_valid = 0; out_ready = 1;
        @(negedge clk); out_ready = 0;
        check("acc_setup", acc, 5'b10000);
        set_entry(64'h3, 5'b00100, 8'h12); in_valid = 1;
        @(negedge clk); in_valid = 0; out_ready = 1; status_clr = 1;
        @(negedge clk); out_ready = 0;
        check("acc_clr_pop", acc, 5'b00100);
        @(negedge clk); status_clr = 0;
        check("acc_clr_alone", acc, 0);

        // Reset mid-stream with a push pending.
        for (int i = 0; i < 2; i++) begin
            set_entry({$urandom, $urandom}, 5'b00010, 8'(80 + i)); in_valid = 1;
            @(negedge clk);
        end
        rst = 1; set_entry(64'h9, 5'b00010, 8'h90);
        @(negedge clk); rst = 0; in_valid = 0;
        check_reset_vals("midrst");
        repeat (4) @(negedge clk);
        check("midrst_no_stale", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fpnew_divsqrt_result_buffer.md
# fpnew_divsqrt_result_buffer

Result buffer that sits directly downstream of the multi-cycle divide/sqrt unit. It accepts each completed result (value, status flags, NaN-box extension bit, tag) over a valid/ready handshake and holds up to DEPTH entries in FIFO order. This lets the iterative unit retire and start its next operation while the writeback arbiter is stalled. It also keeps a sticky OR of the status flags of all retired results, for the CSR fflags update.

## Interface
Parameters:
- WIDTH, 64, result width in bits; matches the divsqrt unit's maximum enabled FP width.
- DEPTH, 4, number of entries; legal range 1..16, any integer (not restricted to powers of two).
- TAG_WIDTH, 8, width of the opaque tag carried with each result.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- flush_i  in  1  discards all buffered entries.
- in_valid_i  in  1  upstream result valid.
- in_ready_o  out  1  buffer can accept an entry.
- in_result_i  in  WIDTH  result value.
- in_status_i  in  5  status flags {NV, DZ, OF, UF, NX}.
- in_ext_bit_i  in  1  NaN-box extension bit.
- in_tag_i  in  TAG_WIDTH  tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream accepts the head entry.
- out_result_o  out  WIDTH  head result.
- out_status_o  out  5  head status.
- out_ext_bit_o  out  1  head extension bit.
- out_tag_o  out  TAG_WIDTH  head tag.
- usage_o  out  $clog2(DEPTH+1)  number of valid entries.
- status_acc_o  out  5  sticky OR of the status of every popped entry.
- status_clr_i  in  1  clears status_acc_o.
- busy_o  out  1  asserted while any entry is held (usage_o != 0).

## Operation
- Storage: circular array of DEPTH entries, with write pointer wr_q, read pointer rd_q and counter cnt_q.
- Pointers wrap from DEPTH-1 to 0; wrap-around must be correct for non-power-of-two DEPTH.
- Push = in_valid_i & in_ready_o.
  - Writes the entry at wr_q.
  - Advances wr_q.
- Pop = out_valid_o & out_ready_i.
  - Advances rd_q.
  - Updates the status accumulator.
- in_ready_o = (cnt_q != DEPTH).
  - Purely registered; there is no combinational path from out_ready_i to in_ready_o.
  - When the buffer is full, a push is refused even if a pop occurs in the same cycle.
- out_valid_o = (cnt_q != 0).
  - Head fields are read combinationally from entry rd_q.
  - While out_valid_o=0, head fields are don't-care; the bench must not check them.
- Simultaneous push and pop with 0 < cnt_q < DEPTH: cnt_q is unchanged and both pointers advance.
- Push into an empty buffer: the entry is not visible as the head until the next cycle. There is no fall-through.
- Flush: wr_q, rd_q and cnt_q go to 0 on the next edge.
  - Any push or pop in the flush cycle is discarded; neither changes state.
  - in_ready_o stays as computed from cnt_q in the flush cycle, so upstream may see a handshake that is silently dropped. This is acceptable because upstream is flushed in the same cycle.
  - The accumulator is not affected by flush.
- Accumulator, next value:
  - status_clr_i=1 with a pop: acc = popped status.
  - status_clr_i=1 without a pop: acc = 0.
  - Otherwise, with a pop: acc = acc | popped status.
  - Otherwise: acc holds.
- Reset dominates flush and status_clr_i.

## Timing
- Reset values:
  - in_ready_o=1.
  - out_valid_o=0.
  - usage_o=0.
  - status_acc_o=0.
  - busy_o=0.
  - The storage array is not reset.
- Latency is 1 cycle: an entry pushed at edge N is presented at out_valid_o after edge N and can be popped in cycle N+1.
- Throughput is 1 entry per cycle in steady state while 0 < cnt_q < DEPTH.
- usage_o, busy_o and status_acc_o reflect register state only; they change only at clock edges.
- If reset is asserted mid-operation, all entries are lost and the outputs return to their reset values after that edge.

## Test plan
- Reset then single entry.
  - Stimulus: after reset, push result=64'h3FF0_0000_0000_0000, status=5'b00001, tag=8'h5A.
  - Next cycle: out_valid_o=1, head matches the pushed values, usage_o=1.
  - Pop with out_ready_i=1: usage_o=0, status_acc_o=5'b00001.
- Fill and back-pressure (DEPTH=4, out_ready_i=0).
  - Stimulus: push tags 1,2,3,4.
  - After the 4th push: in_ready_o=0, usage_o=4.
  - A 5th push held for 3 cycles is not accepted.
  - Then pop: tags come out in order 1..4, and in_ready_o=1 the cycle after the first pop.
- Concurrent push/pop and wrap-around (DEPTH=3).
  - Stimulus: stream 10 entries with random out_ready_i.
  - Required: all tags are popped in order with no loss or duplication, and usage_o never exceeds 3.
- Flush.
  - Stimulus: with 3 entries held, assert flush_i together with a push and a pop.
  - Next cycle: usage_o=0, out_valid_o=0, busy_o=0.
  - status_acc_o is unchanged by the discarded pop.
- Accumulator clear collision.
  - Setup: acc=5'b10000.
  - Stimulus: assert status_clr_i in the same cycle as a pop with status 5'b00100.
  - Required: acc=5'b00100.
  - Then status_clr_i alone gives acc=0.
- Reset mid-stream.
  - Stimulus: assert rst_i with 2 entries held and a push pending.
  - Required: after the edge, all outputs are at their reset values and no stale entry appears later.
